// File: rtl/race_state_decoder_pkg.sv
// Shared constants and helpers for the game-state decoder.
package race_pkg;

    // Encoder state codes; 2 and 7 are never legal.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTING   = 3'd1,
        ST_COUNTDOWN = 3'd3,
        ST_RACING    = 3'd4,
        ST_PAUSE     = 3'd5,
        ST_FINISH    = 3'd6
    } race_state_e;

    localparam int unsigned STATE_W            = 3;
    localparam int unsigned CD_W               = 2;
    localparam int unsigned LAP_W              = 3;
    localparam int unsigned SEC_W              = 10;
    localparam int unsigned SECOND_DEFAULT     = 100_000_000;
    localparam int unsigned LAP_TARGET_DEFAULT = 3;
    localparam logic [SEC_W-1:0] SEC_SAT       = 10'd999;

    // True for any code the encoder is allowed to send.
    function automatic logic is_legal(input logic [STATE_W-1:0] code);
        return !((code == 3'd2) || (code == 3'd7));
    endfunction

    // Seconds increment that sticks at the display limit.
    function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v);
        return (v >= SEC_SAT) ? SEC_SAT : v + 10'd1;
    endfunction

endpackage

// File: rtl/race_state_decoder_if.sv
// Encoder-to-decoder game-state bus plus the decoder's status outputs.
interface race_state_decoder_if;
    import race_pkg::*;

    logic [STATE_W-1:0] state;
    logic [CD_W-1:0]    countdown_val;
    logic               lap_pulse;

    logic               in_idle;
    logic               in_setting;
    logic               in_countdown;
    logic               in_racing;
    logic               in_paused;
    logic               in_finish;
    logic               race_go_pulse;
    logic               beep_pulse;
    logic [LAP_W-1:0]   lap_count;
    logic [SEC_W-1:0]   race_sec;
    logic [SEC_W-1:0]   best_lap_sec;
    logic               is_game_end;
    logic               illegal_state;

    // Encoder / track side.
    modport master (
        output state, countdown_val, lap_pulse,
        input  in_idle, in_setting, in_countdown, in_racing, in_paused, in_finish,
        input  race_go_pulse, beep_pulse, lap_count, race_sec, best_lap_sec,
        input  is_game_end, illegal_state
    );

    // Decoder side.
    modport slave (
        input  state, countdown_val, lap_pulse,
        output in_idle, in_setting, in_countdown, in_racing, in_paused, in_finish,
        output race_go_pulse, beep_pulse, lap_count, race_sec, best_lap_sec,
        output is_game_end, illegal_state
    );

endinterface

// File: rtl/race_state_decoder_sec_prescaler.sv
// Divides the clock down to one-cycle race-timer ticks, one per SECOND cycles.
module sec_prescaler #(
    parameter int unsigned SECOND = race_pkg::SECOND_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (SECOND > 1) ? $clog2(SECOND) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(SECOND - 1));

    // Cycle counter: clear wins, otherwise count while enabled and wrap at SECOND-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick_c = i_en && !i_clr && w_wrap;

endmodule

// File: rtl/race_state_decoder.sv
// Game-state decoder: phase enables, countdown/start pulses, race timer, laps.
// Optional macro RACE_STATE_DECODER_BEST_LAP_EN adds best-lap timing.
module race_state_decoder
    import race_pkg::*;
#(
    parameter int unsigned SECOND     = SECOND_DEFAULT,
    parameter int unsigned LAP_TARGET = LAP_TARGET_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    race_state_decoder_if.slave  bus
);

    logic [STATE_W-1:0] r_state_q;
    logic [STATE_W-1:0] r_state_d;
    logic [CD_W-1:0]    r_cd_q;

    logic               r_in_idle;
    logic               r_in_setting;
    logic               r_in_countdown;
    logic               r_in_racing;
    logic               r_in_paused;
    logic               r_in_finish;
    logic               r_illegal;
    logic               r_race_go;
    logic               r_beep;
    logic [LAP_W-1:0]   r_lap_count;
    logic [SEC_W-1:0]   r_race_sec;
    logic               r_game_end;

    logic               w_q_idle;
    logic               w_q_racing;
    logic               w_q_clear;
    logic               w_tick;
    logic               w_lap_accept;

    assign w_q_idle     = (r_state_q == ST_IDLE);
    assign w_q_racing   = (r_state_q == ST_RACING);
    assign w_q_clear    = w_q_idle || (r_state_q == ST_COUNTDOWN);
    assign w_lap_accept = bus.lap_pulse && w_q_racing && (r_lap_count < LAP_W'(LAP_TARGET));

    // Input pipeline: state_q, the one-cycle-older state_d, and the last countdown digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_state_d <= ST_IDLE;
            r_cd_q    <= '0;
        end else begin
            r_state_q <= bus.state;
            r_state_d <= r_state_q;
            r_cd_q    <= bus.countdown_val;
        end
    end

    // One-hot phase and sticky illegal flag, registered alongside state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_idle      <= 1'b1;
            r_in_setting   <= 1'b0;
            r_in_countdown <= 1'b0;
            r_in_racing    <= 1'b0;
            r_in_paused    <= 1'b0;
            r_in_finish    <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_in_idle      <= (bus.state == ST_IDLE);
            r_in_setting   <= (bus.state == ST_SETTING);
            r_in_countdown <= (bus.state == ST_COUNTDOWN);
            r_in_racing    <= (bus.state == ST_RACING);
            r_in_paused    <= (bus.state == ST_PAUSE);
            r_in_finish    <= (bus.state == ST_FINISH);
            if (!is_legal(bus.state)) begin
                r_illegal <= 1'b1;
            end else if (bus.state == ST_IDLE) begin
                r_illegal <= 1'b0;
            end
        end
    end

    // Start pulse on COUNTDOWN->RACING only; beep on every strict countdown decrease.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_race_go <= 1'b0;
            r_beep    <= 1'b0;
        end else begin
            r_race_go <= (r_state_d == ST_COUNTDOWN) && w_q_racing;
            r_beep    <= (bus.countdown_val < r_cd_q);
        end
    end

    sec_prescaler #(
        .SECOND   (SECOND)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_q_racing),
        .i_clr    (w_q_clear),
        .o_tick_c (w_tick)
    );

    // Race seconds, lap count and end-of-race level; IDLE clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_race_sec  <= '0;
            r_lap_count <= '0;
            r_game_end  <= 1'b0;
        end else if (w_q_idle) begin
            r_race_sec  <= '0;
            r_lap_count <= '0;
            r_game_end  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_race_sec <= sat_inc(r_race_sec);
            end
            if (w_lap_accept) begin
                r_lap_count <= r_lap_count + LAP_W'(1);
                if (r_lap_count == LAP_W'(LAP_TARGET - 1)) begin
                    r_game_end <= 1'b1;
                end
            end
        end
    end

`ifdef RACE_STATE_DECODER_BEST_LAP_EN
    logic [SEC_W-1:0] r_lap_sec;
    logic [SEC_W-1:0] r_best_lap;
    logic [SEC_W-1:0] w_lap_sec_now;

    // A tick landing on the lap-crossing cycle still counts toward that lap.
    assign w_lap_sec_now = w_tick ? sat_inc(r_lap_sec) : r_lap_sec;

    // Per-lap seconds and running minimum over accepted laps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap_sec  <= '0;
            r_best_lap <= SEC_SAT;
        end else if (w_q_idle) begin
            r_lap_sec  <= '0;
            r_best_lap <= SEC_SAT;
        end else if (w_lap_accept) begin
            r_lap_sec <= '0;
            if (w_lap_sec_now < r_best_lap) begin
                r_best_lap <= w_lap_sec_now;
            end
        end else if (w_tick) begin
            r_lap_sec <= sat_inc(r_lap_sec);
        end
    end

    assign bus.best_lap_sec = r_best_lap;
`else
    assign bus.best_lap_sec = SEC_SAT;
`endif

    assign bus.in_idle       = r_in_idle;
    assign bus.in_setting    = r_in_setting;
    assign bus.in_countdown  = r_in_countdown;
    assign bus.in_racing     = r_in_racing;
    assign bus.in_paused     = r_in_paused;
    assign bus.in_finish     = r_in_finish;
    assign bus.race_go_pulse = r_race_go;
    assign bus.beep_pulse    = r_beep;
    assign bus.lap_count     = r_lap_count;
    assign bus.race_sec      = r_race_sec;
    assign bus.is_game_end   = r_game_end;
    assign bus.illegal_state = r_illegal;

endmodule

// File: tb/tb_race_state_decoder.sv
// Scoreboard bench for race_state_decoder: a seconds/laps reference model
// predicts every cycle's outputs; a monitor compares them after each clock edge.
module tb_race_state_decoder;

    localparam int SEC = 10;
    localparam int TGT = 3;
`ifdef RACE_STATE_DECODER_BEST_LAP_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] en;      // idle, setting, countdown, racing, paused, finish (bit 0..5)
        logic       go;
        logic       beep;
        logic [2:0] laps;
        logic [9:0] sec;
        logic [9:0] best;
        logic       gend;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    race_state_decoder_if u_if ();

    race_state_decoder #(
        .SECOND     (SEC),
        .LAP_TARGET (TGT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    int   n_beep   = 0;
    int   n_go     = 0;
    exp_t exp_q[$];

    // Reference model: seconds are whole racing-cycle multiples of SEC, lap
    // times are differences of the running tick total.
    int m_q, m_d, m_cd, m_cycles, m_ticks, m_last, m_laps, m_best;
    bit m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_d = 0; m_cd = 0; m_cycles = 0; m_ticks = 0;
        m_last = 0; m_laps = 0; m_best = 999; m_ill = 1'b0;
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e      = '0;
        e.en   = 6'b000001;
        e.best = 10'd999;
        return e;
    endfunction

    task automatic model_step(input logic [2:0] s, input logic [1:0] cd, input logic lap, output exp_t e);
        int lap_s;
        e = '0;
        case (m_q)
            0: begin m_cycles = 0; m_ticks = 0; m_last = 0; m_laps = 0; m_best = 999; end
            3: m_cycles = 0;
            4: begin m_cycles++; if (m_cycles % SEC == 0) m_ticks++; end
            default: ;
        endcase
        if (lap && m_q == 4 && m_laps < TGT) begin
            lap_s = m_ticks - m_last;
            if (lap_s > 999) lap_s = 999;
            if (BEST_EN && lap_s < m_best) m_best = lap_s;
            m_last = m_ticks;
            m_laps++;
        end
        e.go   = (m_d == 3 && m_q == 4);
        e.beep = (int'(cd) < m_cd);
        if (s == 3'd2 || s == 3'd7) m_ill = 1'b1;
        else if (s == 3'd0)         m_ill = 1'b0;
        case (s)
            3'd0: e.en[0] = 1'b1;
            3'd1: e.en[1] = 1'b1;
            3'd3: e.en[2] = 1'b1;
            3'd4: e.en[3] = 1'b1;
            3'd5: e.en[4] = 1'b1;
            3'd6: e.en[5] = 1'b1;
            default: ;
        endcase
        e.laps = 3'(m_laps);
        e.sec  = 10'((m_ticks > 999) ? 999 : m_ticks);
        e.best = 10'(m_best);
        e.gend = (m_laps == TGT);
        e.ill  = m_ill;
        m_d  = m_q;
        m_q  = int'(s);
        m_cd = int'(cd);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its prediction.
    task automatic step(input logic [2:0] s, input logic [1:0] cd, input logic lap);
        exp_t e;
        @(negedge clk);
        rst               = 1'b1;
        u_if.state        = s;
        u_if.countdown_val = cd;
        u_if.lap_pulse    = lap;
        model_step(s, cd, lap, e);
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic steps(input int n, input logic [2:0] s, input logic [1:0] cd);
        for (int i = 0; i < n; i++) step(s, cd, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_idle"},      32'(u_if.in_idle), 1);
        chk({tag, "_other_en"},     32'({u_if.in_setting, u_if.in_countdown, u_if.in_racing,
                                         u_if.in_paused, u_if.in_finish}), 0);
        chk({tag, "_pulses"},       32'({u_if.race_go_pulse, u_if.beep_pulse}), 0);
        chk({tag, "_lap_count"},    32'(u_if.lap_count), 0);
        chk({tag, "_race_sec"},     32'(u_if.race_sec), 0);
        chk({tag, "_best_lap_sec"}, 32'(u_if.best_lap_sec), 999);
        chk({tag, "_is_game_end"},  32'(u_if.is_game_end), 0);
        chk({tag, "_illegal"},      32'(u_if.illegal_state), 0);
    endtask

    // Asynchronous reset mid-cycle; held low through the next rising edge.
    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        model_reset();
        exp_q.push_back(reset_exp());
        n_push++;
    endtask

    function automatic logic [2:0] pick_state();
        int unsigned r = $urandom_range(0, 15);
        if (r < 2)       return 3'd0;
        else if (r == 2) return 3'd1;
        else if (r < 5)  return 3'd3;
        else if (r < 11) return 3'd4;
        else if (r < 13) return 3'd5;
        else if (r == 13) return 3'd6;
        else if (r == 14) return 3'd2;
        else              return 3'd7;
    endfunction

    // Monitor: after every rising edge compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_beep += int'(u_if.beep_pulse);
            n_go   += int'(u_if.race_go_pulse);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                chk("in_idle",       32'(u_if.in_idle),       32'(e.en[0]));
                chk("in_setting",    32'(u_if.in_setting),    32'(e.en[1]));
                chk("in_countdown",  32'(u_if.in_countdown),  32'(e.en[2]));
                chk("in_racing",     32'(u_if.in_racing),     32'(e.en[3]));
                chk("in_paused",     32'(u_if.in_paused),     32'(e.en[4]));
                chk("in_finish",     32'(u_if.in_finish),     32'(e.en[5]));
                chk("race_go_pulse", 32'(u_if.race_go_pulse), 32'(e.go));
                chk("beep_pulse",    32'(u_if.beep_pulse),    32'(e.beep));
                chk("lap_count",     32'(u_if.lap_count),     32'(e.laps));
                chk("race_sec",      32'(u_if.race_sec),      32'(e.sec));
                chk("best_lap_sec",  32'(u_if.best_lap_sec),  32'(e.best));
                chk("is_game_end",   32'(u_if.is_game_end),   32'(e.gend));
                chk("illegal_state", 32'(u_if.illegal_state), 32'(e.ill));
            end
        end
    end

    // Stimulus: directed race scenarios, then randomized traffic.
    initial begin
        logic [2:0] rs;
        logic [1:0] rcd;
        int         hold;
        u_if.state = 3'd0; u_if.countdown_val = 2'd0; u_if.lap_pulse = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset("por");

        steps(3, 3'd0, 2'd0);
        chk("idle_after_release", 32'(u_if.in_idle), 1);
        steps(3, 3'd1, 2'd0);
        step(3'd3, 2'd3, 1'b0);
        step(3'd3, 2'd3, 1'b0);
        chk("countdown_entry", 32'({u_if.in_countdown, u_if.in_idle, u_if.in_setting}), 32'b100);

        // Countdown 3-2-1-0 with RACING entered on the last step.
        n_beep = 0; n_go = 0;
        steps(2, 3'd3, 2'd3);
        steps(4, 3'd3, 2'd2);
        steps(4, 3'd3, 2'd1);
        steps(35, 3'd4, 2'd0);
        for (int i = 0; i < 20; i++) step(3'd5, 2'd0, i == 10);
        steps(15, 3'd4, 2'd0);
        steps(3, 3'd5, 2'd0);
        chk("beep_count", 32'(n_beep), 3);
        chk("go_count", 32'(n_go), 1);
        chk("race_sec_after_pause", 32'(u_if.race_sec), 5);
        chk("pause_lap_ignored", 32'(u_if.lap_count), 0);

        // Three accepted laps, then duplicates after the target.
        for (int l = 0; l < 3; l++) begin
            steps(3, 3'd4, 2'd0);
            step(3'd4, 2'd0, 1'b1);
        end
        steps(2, 3'd4, 2'd0);
        step(3'd4, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(3'd5, 2'd0, i == 1);
        chk("lap_target", 32'(u_if.lap_count), 3);
        chk("game_end_set", 32'(u_if.is_game_end), 1);
        steps(3, 3'd6, 2'd0);
        chk("game_end_finish", 32'(u_if.is_game_end), 1);
        chk("go_no_resume_pulse", 32'(n_go), 1);
        steps(3, 3'd0, 2'd0);
        chk("idle_clear", 32'({u_if.lap_count, u_if.race_sec, u_if.is_game_end}), 0);

        // Second race: laps of 4 s then 2 s.
        steps(2, 3'd1, 2'd0);
        steps(2, 3'd3, 2'd3);
        steps(2, 3'd3, 2'd2);
        steps(2, 3'd3, 2'd1);
        steps(42, 3'd4, 2'd0);
        step(3'd4, 2'd0, 1'b1);
        step(3'd4, 2'd0, 1'b0);
        chk("best_lap_first", 32'(u_if.best_lap_sec), BEST_EN ? 4 : 999);
        steps(19, 3'd4, 2'd0);
        step(3'd4, 2'd0, 1'b1);
        steps(2, 3'd4, 2'd0);
        chk("best_lap_second", 32'(u_if.best_lap_sec), BEST_EN ? 2 : 999);
        reset_pulse();
        steps(3, 3'd0, 2'd0);

        // Illegal codes: sticky until IDLE.
        steps(2, 3'd7, 2'd0);
        chk("illegal_en_off", 32'({u_if.in_idle, u_if.in_setting, u_if.in_countdown,
                                   u_if.in_racing, u_if.in_paused, u_if.in_finish}), 0);
        chk("illegal_set", 32'(u_if.illegal_state), 1);
        steps(2, 3'd4, 2'd0);
        chk("illegal_sticky", 32'(u_if.illegal_state), 1);
        steps(2, 3'd0, 2'd0);
        chk("illegal_cleared", 32'(u_if.illegal_state), 0);

        // Randomized traffic.
        hold = 0; rs = 3'd0; rcd = 2'd0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                rs   = pick_state();
                hold = $urandom_range(1, 25);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) rcd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) reset_pulse();
            else step(rs, rcd, $urandom_range(0, 5) == 0);
        end
        steps(3, 3'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("monitor_pops", 32'(n_pop), 32'(n_push));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
